// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: wait-stated byte RAM responder that stalls the CPU via its enable input
module cpu_mem_responder #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WAIT_STATES    = 2,
  parameter logic [DATA_WIDTH-1:0] OPEN_BUS_VALUE = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_rdwr,
  input  logic                  which_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  cpu_enable,
  output logic                  ack,
  output logic                  bus_err,
  output logic                  busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_c;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_c, rd_data_q;
  logic we_q, we_c, win_q, win_c, ack_q, err_q, idle, commit;
  logic [ADDR_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];
  // One extra bit keeps addresses below BASE_ADDR from wrapping into the window;
  // any set bit at or above MEM_DEPTH_LOG2 means outside.
  assign diff  = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign idle  = state_q == S_IDLE;
  // With zero wait states the commit happens on the capture edge, so live inputs are used then.
  assign we_c    = idle ? which_rdwr : we_q;
  assign win_c   = idle ? diff[ADDR_WIDTH:MEM_DEPTH_LOG2] == '0 : win_q;
  assign idx_c   = idle ? diff[MEM_DEPTH_LOG2-1:0] : idx_q;
  assign wdata_c = idle ? wr_data : wdata_q;
  assign commit  = state_q != S_DONE && state_d == S_DONE;
  assign cpu_enable = (idle && !req_rdwr) || state_q == S_DONE;
  assign busy    = !idle;
  assign ack     = ack_q;
  assign bus_err = err_q;
  assign rd_data = rd_data_q;
  // Next-state logic: capture in IDLE, count down wait states, single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_rdwr) begin
        state_d = WAIT_STATES == 0 ? S_DONE : S_WAIT;
        cnt_d   = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
      end
      S_WAIT: if (cnt_q == 4'd0) state_d = S_DONE; else cnt_d = cnt_q - 4'd1;
      default: state_d = S_IDLE;
    endcase
  end
  // State, latched request, completion flags and RAM; RAM is never cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      win_q     <= 1'b0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req_rdwr) begin
        idx_q   <= idx_c;
        wdata_q <= wdata_c;
        we_q    <= we_c;
        win_q   <= win_c;
      end
      ack_q <= commit;
      err_q <= commit && !win_c;
      if (commit && !we_c) rd_data_q <= win_c ? mem[idx_c] : OPEN_BUS_VALUE;
      if (commit && we_c && win_c) mem[idx_c] <= wdata_c;
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed checks of a 2-wait-state and a 0-wait-state responder
module tb_cpu_mem_responder;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0, req_a = 1'b0, req_b = 1'b0, which = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0] wd = '0, rd_a, rd_b, rd_m;
  logic en_a, en_b, ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic en_m, ack_m, err_m, busy_m;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cpu_mem_responder #(.WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst), .req_rdwr(req_a), .which_rdwr(which), .addr(addr), .wr_data(wd),
    .rd_data(rd_a), .cpu_enable(en_a), .ack(ack_a), .bus_err(err_a), .busy(busy_a));
  cpu_mem_responder #(.WAIT_STATES(0), .BASE_ADDR(16'h0100)) dut_b (
    .clk(clk), .rst(rst), .req_rdwr(req_b), .which_rdwr(which), .addr(addr), .wr_data(wd),
    .rd_data(rd_b), .cpu_enable(en_b), .ack(ack_b), .bus_err(err_b), .busy(busy_b));
  assign en_m   = sel ? en_b : en_a;
  assign ack_m  = sel ? ack_b : ack_a;
  assign err_m  = sel ? err_b : err_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign rd_m   = sel ? rd_b : rd_a;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic v);
    req_a = v & !sel;
    req_b = v & sel;
  endtask
  // Runs one access, counting stalled cycles until ack; inputs are scrambled after capture.
  task automatic acc(input logic w, input logic [15:0] a, input logic [7:0] d,
                     output int lows, output logic got, output logic [7:0] rd,
                     output logic err, output logic en);
    which = w; addr = a; wd = d; set_req(1'b1); lows = 0;
    #1;
    for (int i = 0; i < 20 && !ack_m; i++) begin
      if (!en_m) lows++;
      tick();
      set_req(1'b0); which = !w; addr = 16'hFFFF; wd = ~d;
      #1;
    end
    got = ack_m; rd = rd_m; err = err_m; en = en_m;
    tick();
  endtask
  int lows, t1, t2, n;
  logic got, err, en, en_gap;
  logic [7:0] rd;
  initial begin
    tick();
    chk("rst_en", 16'(en_a), 16'h1);
    chk("rst_ack", 16'(ack_a), 16'h0);
    chk("rst_busy", 16'(busy_a), 16'h0);
    chk("rst_rd", 16'(rd_a), 16'h00);
    rst = 1'b0;
    tick();
    acc(1'b1, 16'h0010, 8'hA5, lows, got, rd, err, en);
    chk("wr_lows", 16'(lows), 16'd3);
    chk("wr_ack", 16'(got), 16'h1);
    chk("wr_err", 16'(err), 16'h0);
    chk("wr_en_done", 16'(en), 16'h1);
    chk("wr_ack_clear", 16'(ack_a), 16'h0);
    acc(1'b0, 16'h0010, 8'h00, lows, got, rd, err, en);
    chk("rd_lows", 16'(lows), 16'd3);
    chk("rd_data", 16'(rd), 16'hA5);
    chk("rd_en_done", 16'(en), 16'h1);
    acc(1'b0, 16'h2329, 8'h00, lows, got, rd, err, en);
    chk("oob_rd", 16'(rd), 16'hFF);
    chk("oob_ack", 16'(got), 16'h1);
    chk("oob_err", 16'(err), 16'h1);
    acc(1'b0, 16'hFFFF, 8'h00, lows, got, rd, err, en);
    chk("top_err", 16'(err), 16'h1);
    acc(1'b0, 16'h0FFF, 8'h00, lows, got, rd, err, en);
    chk("edge_err", 16'(err), 16'h0);
    acc(1'b1, 16'h0000, 8'h5A, lows, got, rd, err, en);
    acc(1'b1, 16'h1000, 8'h3C, lows, got, rd, err, en);
    chk("oob_wr_err", 16'(err), 16'h1);
    acc(1'b0, 16'h0000, 8'h00, lows, got, rd, err, en);
    chk("no_alias", 16'(rd), 16'h5A);
    acc(1'b1, 16'h0010, 8'h99, lows, got, rd, err, en);
    chk("rd_hold", 16'(rd_a), 16'h5A);
    which = 1'b0; addr = 16'h0010; set_req(1'b1); n = 0; t1 = 0; t2 = 0; en_gap = 1'bx;
    #1;
    for (int c = 0; c < 30 && n < 2; c++) begin
      if (n == 1 && c == t1 + 1) en_gap = en_m;
      if (ack_m) begin
        if (n == 0) t1 = c; else t2 = c;
        n++;
      end
      if (n < 2) tick();
    end
    chk("b2b_acks", 16'(n), 16'd2);
    chk("b2b_spacing", 16'(t2 - t1), 16'd4);
    chk("b2b_gap_en", 16'(en_gap), 16'h0);
    chk("b2b_rd", 16'(rd_a), 16'h99);
    set_req(1'b0);
    for (int c = 0; c < 10 && busy_m; c++) tick();
    chk("b2b_idle", 16'(busy_m), 16'h0);
    acc(1'b1, 16'h0020, 8'h11, lows, got, rd, err, en);
    which = 1'b1; addr = 16'h0020; wd = 8'h77; set_req(1'b1);
    tick();
    set_req(1'b0);
    tick();
    chk("mid_busy", 16'(busy_a), 16'h1);
    rst = 1'b1;
    #1;
    chk("mr_busy", 16'(busy_a), 16'h0);
    chk("mr_en", 16'(en_a), 16'h1);
    chk("mr_rd", 16'(rd_a), 16'h00);
    tick();
    chk("mr_ack", 16'(ack_a), 16'h0);
    rst = 1'b0;
    tick();
    chk("mr_ack2", 16'(ack_a), 16'h0);
    tick();
    chk("mr_ack3", 16'(ack_a), 16'h0);
    acc(1'b0, 16'h0020, 8'h00, lows, got, rd, err, en);
    chk("mr_old", 16'(rd), 16'h11);
    sel = 1'b1;
    acc(1'b1, 16'h0105, 8'h42, lows, got, rd, err, en);
    chk("ws0_wr_lows", 16'(lows), 16'd1);
    chk("ws0_wr_ack", 16'(got), 16'h1);
    chk("ws0_wr_err", 16'(err), 16'h0);
    chk("ws0_ack_clear", 16'(ack_b), 16'h0);
    acc(1'b0, 16'h0105, 8'h00, lows, got, rd, err, en);
    chk("ws0_rd_lows", 16'(lows), 16'd1);
    chk("ws0_rd", 16'(rd), 16'h42);
    chk("ws0_en_done", 16'(en), 16'h1);
    acc(1'b0, 16'h00FF, 8'h00, lows, got, rd, err, en);
    chk("ws0_below_err", 16'(err), 16'h1);
    chk("ws0_below_rd", 16'(rd), 16'hFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the Cpu bus (req_rdwr / which_rdwr / addr / data_out in, data_in out). It owns a synchronous byte RAM mapped at a configurable address window and inserts configurable wait states. It stalls the CPU through the CPU's enable input until each access completes. It sits between Cpu and its memory in the top level, and is the reference memory model for CPU benches.

Parameters:
ADDR_WIDTH, 16, CPU address width (16-bit space for now).
DATA_WIDTH, 8, bus data width.
MEM_DEPTH_LOG2, 12, log2 of RAM bytes (default 4096).
BASE_ADDR, 16'h0000, first address of the RAM window.
WAIT_STATES, 2, extra stall cycles per access (0..15).
OPEN_BUS_VALUE, 8'hFF, read data returned outside the window.

Ports:
clk  in  1  system clock, all state on posedge.
rst  in  1  asynchronous, active-high reset.
req_rdwr  in  1  CPU requests an access.
which_rdwr  in  1  0 = read, 1 = write (ENUM__CPU_WH_RDWR__READ / __WRITE).
addr  in  ADDR_WIDTH  access address.
wr_data  in  DATA_WIDTH  write data (CPU data_out).
rd_data  out  DATA_WIDTH  read data (CPU data_in).
cpu_enable  out  1  drives the CPU enable input; 0 = stall.
ack  out  1  one-cycle pulse on completion.
bus_err  out  1  one-cycle pulse, with ack, when addr is outside the window.
busy  out  1  transaction in progress (state != IDLE).

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, rd_data=0, ack=0, bus_err=0, busy=0.
  - cpu_enable=1 unless req_rdwr=1, because cpu_enable is combinational.
  - RAM contents are not cleared.
  - A write not yet committed is discarded.
- States:
  - IDLE: no transaction.
  - WAIT: counting wait states.
  - DONE: completion cycle.
- cpu_enable = (state==IDLE && !req_rdwr) || state==DONE. This is the only combinational output. The CPU is frozen from the cycle req_rdwr is seen until DONE.
- IDLE, req_rdwr=1 at posedge (capture edge):
  - Latch addr, which_rdwr, wr_data and the in-window flag.
  - Go to WAIT with counter=WAIT_STATES-1; if WAIT_STATES==0, go straight to DONE.
- WAIT: counter==0 -> DONE, else decrement. Inputs are ignored; the latched values are used.
- Commit edge (the edge entering DONE):
  - Write in window: RAM[addr-BASE_ADDR] <= wr_data. rd_data is unchanged.
  - Read in window: rd_data <= RAM[addr-BASE_ADDR].
  - Out of window: writes are dropped; reads give rd_data <= OPEN_BUS_VALUE.
  - ack <= 1; bus_err <= !in_window.
- DONE: lasts 1 cycle. ack / bus_err are high, cpu_enable=1, so the CPU samples rd_data on the closing edge. Then go to IDLE, clearing ack and bus_err.
- rd_data holds its value until the next read commit.
- Latency: capture edge to DONE = WAIT_STATES+1 edges. cpu_enable is low for WAIT_STATES+1 cycles per access.
- Back-to-back: DONE always returns to IDLE. If req_rdwr is still 1 in IDLE, that cycle is a new capture and cpu_enable stays 0. Minimum spacing is WAIT_STATES+2 cycles.
- Window test: in_window = (addr >= BASE_ADDR) && (addr - BASE_ADDR < 2**MEM_DEPTH_LOG2). The subtraction is done at ADDR_WIDTH+1 bits, so there is no wrap at 16'hFFFF.
- The RAM index uses the low MEM_DEPTH_LOG2 bits of (addr-BASE_ADDR).
- A change of req_rdwr or which_rdwr during WAIT or DONE has no effect on the current transaction.

Test Plan:
- Reset: rst=1 mid-run, req_rdwr=0 -> immediately cpu_enable=1, ack=0, bus_err=0, busy=0, rd_data=8'h00; state IDLE after release.
- Write then read, WAIT_STATES=2:
  - Write 8'hA5 to 16'h0010 -> cpu_enable=0 for 3 cycles, then DONE with ack=1, bus_err=0.
  - Read 16'h0010 -> rd_data=8'hA5 in DONE, cpu_enable=1 in that cycle.
- Out-of-window access, BASE_ADDR=0, depth 4096:
  - Read 16'h2329 -> rd_data=8'hFF, ack=1, bus_err=1.
  - Write 8'h3C to 16'h1000, then read 16'h0000 -> the RAM value is unchanged (no alias).
- Back-to-back: hold req_rdwr=1 through DONE -> IDLE cycle with cpu_enable=0, second capture; two ack pulses 4 cycles apart with WAIT_STATES=2.
- Reset mid-operation: write 8'h77 to 16'h0020 (prior value 8'h11); assert rst during WAIT -> no commit, no ack; a subsequent read returns 8'h11.
- WAIT_STATES=0 instance: read captured at edge n -> DONE in the cycle after edge n, ack high one cycle, cpu_enable low exactly 1 cycle.
